// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE job sequencer: FSM states and PE control-pin codes.
// Ports: none (package only).
// Codes chosen so that 2'b00 on every Sel_* pin is the PE no-op.
package pe_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_CALC,
    ST_FEEDBACK,
    ST_CAPTURE,
    ST_EMIT,
    ST_TREE,
    ST_DONE
  } state_t;

  // Sel_cu_go_back codes
  localparam logic [1:0] GB_NONE = 2'b00;
  localparam logic [1:0] GB_PAR  = 2'b01;
  localparam logic [1:0] GB_CAP  = 2'b10;
  localparam logic [1:0] GB_IN   = 2'b11;

  // Sel_adder codes
  localparam logic [1:0] AD_NONE = 2'b00;
  localparam logic [1:0] AD_LANE = 2'b01;
  localparam logic [1:0] AD_TREE = 2'b10;

  // CU operation codes (00 leaves the CU idle)
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_MAC = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pe_seq_timer.sv
// Loadable down-counter with zero flag, used for the CU and adder-tree settle waits.
// Ports: clk/rst, i_clr (force 0), i_load/i_val (load), o_zero (count is 0).
// Latency: loaded value N reaches zero N cycles after the load edge; no backpressure.
module pe_seq_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pe_sequencer.sv
// Sequences one 16-lane PE through clear, load, compute, feedback passes, capture and emit.
// Ports: start/abort/cfg_* job control, ld_req/ld_ack operand handshake, busy/done/out_valid
// status, Sel_* / Is_* / Clear_reg PE control pins. All outputs registered; LOAD waits on ld_ack.
module pe_sequencer
  import pe_ctrl_pkg::*;
#(
  parameter int CU_LAT   = 3,
  parameter int TREE_LAT = 2,
  parameter int PASS_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        cfg_op,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              cfg_fb_in,
  input  logic              cfg_reduce,
  input  logic              cfg_shift,
  input  logic              ld_ack,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic              ld_req,
  output logic [1:0]        Sel_cu,
  output logic [1:0]        Sel_cu_go_back,
  output logic [1:0]        Sel_adder,
  output logic              Is_save_cu_out,
  output logic              Clear_reg,
  output logic              Is_shift_right
);

  localparam int TMR_W = $clog2(max_int(CU_LAT, TREE_LAT) + 1);
  // Timer is loaded on the entry edge, so the state lasts (value + 1) cycles.
  localparam logic [TMR_W-1:0] CU_LD   = TMR_W'(CU_LAT - 1);
  localparam logic [TMR_W-1:0] TREE_LD = TMR_W'(TREE_LAT - 1);

  state_t              r_state, w_state_nxt;
  logic [PASS_W-1:0]   r_passes, w_passes_nxt;
  logic [1:0]          r_op;
  logic                r_fb_in, r_reduce, r_shift;
  logic                w_cap_cfg;

  logic                w_tmr_clr, w_tmr_load, w_tmr_zero;
  logic [TMR_W-1:0]    w_tmr_val;

  // Next-cycle values of every output; registered alongside the state.
  logic                w_busy, w_done, w_out_valid, w_ld_req;
  logic [1:0]          w_sel_cu, w_sel_gb, w_sel_adder;
  logic                w_save, w_clear, w_shift;

  logic                r_busy, r_done, r_out_valid, r_ld_req;
  logic [1:0]          r_sel_cu, r_sel_gb, r_sel_adder;
  logic                r_save, r_clear, r_shift_out;

  pe_seq_timer #(.W(TMR_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_tmr_clr),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_zero (w_tmr_zero)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_passes_nxt = r_passes;
    w_cap_cfg    = 1'b0;
    w_tmr_clr    = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt  = ST_CLEAR;
          w_cap_cfg    = 1'b1;
          w_passes_nxt = cfg_passes;
        end
      end
      ST_CLEAR: w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (ld_ack) begin
          w_state_nxt = ST_CALC;
          w_tmr_load  = 1'b1;
          w_tmr_val   = CU_LD;
        end
      end
      ST_CALC: begin
        if (w_tmr_zero) begin
          w_state_nxt = (r_passes != '0) ? ST_FEEDBACK : ST_CAPTURE;
        end
      end
      ST_FEEDBACK: begin
        w_state_nxt  = ST_CALC;
        w_passes_nxt = r_passes - PASS_W'(1);
        w_tmr_load   = 1'b1;
        w_tmr_val    = CU_LD;
      end
      ST_CAPTURE: w_state_nxt = ST_EMIT;
      ST_EMIT: begin
        if (r_reduce) begin
          w_state_nxt = ST_TREE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TREE_LD;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_TREE: begin
        if (w_tmr_zero) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    if (abort) begin
      w_state_nxt  = ST_IDLE;
      w_passes_nxt = '0;
      w_cap_cfg    = 1'b0;
      w_tmr_load   = 1'b0;
      w_tmr_clr    = 1'b1;
    end

    // Output decode from the state being entered, so pins line up with the state.
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_out_valid = 1'b0;
    w_ld_req    = 1'b0;
    w_sel_cu    = OP_NOP;
    w_sel_gb    = GB_NONE;
    w_sel_adder = AD_NONE;
    w_save      = 1'b0;
    w_clear     = 1'b0;
    w_shift     = 1'b0;

    case (w_state_nxt)
      ST_CLEAR: begin
        w_busy  = 1'b1;
        w_clear = 1'b1;
      end
      ST_LOAD: begin
        w_busy   = 1'b1;
        w_ld_req = 1'b1;
      end
      ST_CALC: begin
        w_busy   = 1'b1;
        w_sel_cu = r_op;
        // Dequantise only on the last compute pass.
        w_shift  = r_shift && (w_passes_nxt == '0);
      end
      ST_FEEDBACK: begin
        w_busy   = 1'b1;
        w_save   = 1'b1;
        w_sel_gb = r_fb_in ? GB_IN : GB_PAR;
      end
      ST_CAPTURE: begin
        w_busy   = 1'b1;
        w_sel_gb = GB_CAP;
      end
      ST_EMIT: begin
        w_busy      = 1'b1;
        w_sel_adder = r_reduce ? AD_TREE : AD_LANE;
      end
      ST_TREE: w_busy = 1'b1;
      ST_DONE: begin
        w_done      = 1'b1;
        w_out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_passes    <= '0;
      r_op        <= '0;
      r_fb_in     <= 1'b0;
      r_reduce    <= 1'b0;
      r_shift     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_ld_req    <= 1'b0;
      r_sel_cu    <= '0;
      r_sel_gb    <= '0;
      r_sel_adder <= '0;
      r_save      <= 1'b0;
      r_clear     <= 1'b0;
      r_shift_out <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_passes <= w_passes_nxt;
      if (w_cap_cfg) begin
        r_op     <= cfg_op;
        r_fb_in  <= cfg_fb_in;
        r_reduce <= cfg_reduce;
        r_shift  <= cfg_shift;
      end
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_out_valid <= w_out_valid;
      r_ld_req    <= w_ld_req;
      r_sel_cu    <= w_sel_cu;
      r_sel_gb    <= w_sel_gb;
      r_sel_adder <= w_sel_adder;
      r_save      <= w_save;
      r_clear     <= w_clear;
      r_shift_out <= w_shift;
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign out_valid      = r_out_valid;
  assign ld_req         = r_ld_req;
  assign Sel_cu         = r_sel_cu;
  assign Sel_cu_go_back = r_sel_gb;
  assign Sel_adder      = r_sel_adder;
  assign Is_save_cu_out = r_save;
  assign Clear_reg      = r_clear;
  assign Is_shift_right = r_shift_out;

endmodule

// File: tb/tb_pe_sequencer.sv
// Testbench for pe_sequencer: per-cycle trace of all outputs against a phase-list model,
// plus a scalar PE model driven by the control pins for the end-to-end sum check.
// Stimulus: directed scenarios and randomized jobs with cfg scrambled after start.
`timescale 1ns/1ps
module tb_pe_sequencer;

  localparam int CU_LAT   = 3;
  localparam int TREE_LAT = 2;
  localparam int PASS_W   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [1:0]        cfg_op = 2'b00;
  logic [PASS_W-1:0] cfg_passes = '0;
  logic              cfg_fb_in = 1'b0;
  logic              cfg_reduce = 1'b0;
  logic              cfg_shift = 1'b0;
  logic              ld_ack = 1'b0;
  logic              busy, done, out_valid, ld_req;
  logic [1:0]        Sel_cu, Sel_cu_go_back, Sel_adder;
  logic              Is_save_cu_out, Clear_reg, Is_shift_right;

  int n_checks = 0;
  int n_fail   = 0;

  // Output vector: busy done out_valid ld_req Sel_cu[2] go_back[2] adder[2] save clear shift
  logic [12:0] obs;
  logic [12:0] exp_q[$];

  assign obs = {busy, done, out_valid, ld_req, Sel_cu, Sel_cu_go_back, Sel_adder,
                Is_save_cu_out, Clear_reg, Is_shift_right};

  pe_sequencer #(.CU_LAT(CU_LAT), .TREE_LAT(TREE_LAT), .PASS_W(PASS_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .cfg_op         (cfg_op),
    .cfg_passes     (cfg_passes),
    .cfg_fb_in      (cfg_fb_in),
    .cfg_reduce     (cfg_reduce),
    .cfg_shift      (cfg_shift),
    .ld_ack         (ld_ack),
    .busy           (busy),
    .done           (done),
    .out_valid      (out_valid),
    .ld_req         (ld_req),
    .Sel_cu         (Sel_cu),
    .Sel_cu_go_back (Sel_cu_go_back),
    .Sel_adder      (Sel_adder),
    .Is_save_cu_out (Is_save_cu_out),
    .Clear_reg      (Clear_reg),
    .Is_shift_right (Is_shift_right)
  );

  always #5 clk = ~clk;

  // Scalar PE model (all 16 lanes identical: In=2, Par=3).
  int pe_in, pe_par, pe_cu, pe_cap, pe_total;
  always @(posedge clk) begin
    if (Clear_reg) begin
      pe_in <= 0; pe_par <= 0; pe_cap <= 0; pe_total <= 0;
    end
    if (ld_req && ld_ack) begin
      pe_in <= 2; pe_par <= 3;
    end
    if (Sel_cu == 2'b10) pe_cu <= pe_in * pe_par;
    else if (Sel_cu == 2'b01) pe_cu <= pe_in + pe_par;
    if (Is_save_cu_out && Sel_cu_go_back == 2'b01) pe_par <= pe_cu;
    if (Is_save_cu_out && Sel_cu_go_back == 2'b11) pe_in <= pe_cu;
    if (Sel_cu_go_back == 2'b10) pe_cap <= pe_cu;
    if (Sel_adder == 2'b10) pe_total <= 16 * pe_cap;
  end

  function automatic logic [12:0] mk(input logic b, input logic d, input logic v, input logic lr,
                                     input logic [1:0] sc, input logic [1:0] gb,
                                     input logic [1:0] ad, input logic sv, input logic cl,
                                     input logic sh);
    return {b, d, v, lr, sc, gb, ad, sv, cl, sh};
  endfunction

  // Expected per-cycle output list for one job, starting the cycle after the start edge.
  task automatic build_exp(input logic [1:0] op, input int passes, input logic fb,
                           input logic red, input logic sh, input int ackd);
    exp_q.delete();
    exp_q.push_back(mk(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0));
    for (int i = 0; i <= ackd; i++)
      exp_q.push_back(mk(1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    for (int p = passes; p >= 0; p--) begin
      for (int c = 0; c < CU_LAT; c++)
        exp_q.push_back(mk(1, 0, 0, 0, op, 2'b00, 2'b00, 0, 0, sh && (p == 0)));
      if (p > 0)
        exp_q.push_back(mk(1, 0, 0, 0, 2'b00, fb ? 2'b11 : 2'b01, 2'b00, 1, 0, 0));
    end
    exp_q.push_back(mk(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 2'b00, 2'b00, red ? 2'b10 : 2'b01, 0, 0, 0));
    if (red)
      for (int t = 0; t < TREE_LAT; t++)
        exp_q.push_back(mk(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    exp_q.push_back(mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0));
  endtask

  // Runs one job from IDLE and checks every cycle. abort_at / rst_at (>=0) cut the job
  // short at that trace index; noise scrambles cfg and pulses start while busy.
  task automatic run_job(input string name, input logic [1:0] op, input int passes,
                         input logic fb, input logic red, input logic sh, input int ackd,
                         input int abort_at, input int rst_at, input bit noise);
    int nload;
    nload = 0;
    build_exp(op, passes, fb, red, sh, ackd);
    @(negedge clk);
    cfg_op = op; cfg_passes = PASS_W'(passes); cfg_fb_in = fb;
    cfg_reduce = red; cfg_shift = sh; start = 1'b1; abort = 1'b0; ld_ack = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_q[k]) begin
        n_fail++;
        $display("FAIL %s trace[%0d]: got %b expected %b", name, k, obs, exp_q[k]);
      end
      if (noise) begin
        cfg_op = 2'($urandom); cfg_passes = PASS_W'($urandom); cfg_fb_in = 1'($urandom);
        cfg_reduce = 1'($urandom); cfg_shift = 1'($urandom); start = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      ld_ack = exp_q[k][9] && (nload >= ackd);
      if (exp_q[k][9]) nload++;
      if (k == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0; ld_ack = 1'b0;
        for (int j = 0; j < 4; j++) begin
          n_checks++;
          if (obs !== 13'd0) begin
            n_fail++;
            $display("FAIL %s after_abort[%0d]: got %b expected 0", name, j, obs);
          end
          @(negedge clk);
        end
        return;
      end
      if (k == rst_at) begin
        start = 1'b0; ld_ack = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== 13'd0) begin
          n_fail++;
          $display("FAIL %s async_reset: got %b expected 0", name, obs);
        end
        @(negedge clk);
        rst = 1'b1;
        return;
      end
    end
    start = 1'b0; ld_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== 13'd0) begin
      n_fail++;
      $display("FAIL %s idle_after: got %b expected 0", name, obs);
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 0", obs);
    end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b expected 0", obs);
    end
  endtask

  task automatic test_latency();
    int at, tree_cnt, lane_cnt;
    at = -1; tree_cnt = 0; lane_cnt = 0;
    @(negedge clk);
    cfg_op = 2'b10; cfg_passes = '0; cfg_fb_in = 1'b0; cfg_reduce = 1'b1; cfg_shift = 1'b0;
    ld_ack = 1'b1; start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (Sel_adder == 2'b10) tree_cnt++;
      if (Sel_adder == 2'b01) lane_cnt++;
      if (done) begin
        at = c;
        break;
      end
    end
    ld_ack = 1'b0;
    n_checks++;
    if (at != 9) begin
      n_fail++;
      $display("FAIL latency_start_to_done: got %0d expected 9", at);
    end
    n_checks++;
    if (tree_cnt != 1 || lane_cnt != 0) begin
      n_fail++;
      $display("FAIL adder_tree_pulse: got tree=%0d lane=%0d expected tree=1 lane=0",
               tree_cnt, lane_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_idle_start_abort();
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int j = 0; j < 3; j++) begin
      n_checks++;
      if (obs !== 13'd0) begin
        n_fail++;
        $display("FAIL start_with_abort[%0d]: got %b expected 0", j, obs);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pe_sum();
    run_job("pe_sum", 2'b10, 0, 1'b0, 1'b1, 1'b0, 0, -1, -1, 1'b0);
    n_checks++;
    if (pe_total != 96) begin
      n_fail++;
      $display("FAIL pe_out_total: got %0d expected 96", pe_total);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_job("random", 2'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1'($urandom),
              1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), -1, -1, 1'b1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    // Reset while in the second CALC cycle, then a full job from scratch.
    run_job("reset_mid_calc", 2'b01, 1, 1'b0, 1'b0, 1'b0, 0, -1, 3, 1'b0);
    run_job("after_reset", 2'b01, 1, 1'b0, 1'b0, 1'b1, 0, -1, -1, 1'b0);
    test_latency();
    run_job("latency_trace", 2'b10, 0, 1'b0, 1'b1, 1'b0, 0, -1, -1, 1'b0);
    run_job("feedback_in", 2'b10, 2, 1'b1, 1'b0, 1'b1, 0, -1, -1, 1'b1);
    run_job("feedback_par", 2'b11, 1, 1'b0, 1'b1, 1'b1, 1, -1, -1, 1'b0);
    run_job("ld_stall", 2'b01, 0, 1'b0, 1'b0, 1'b0, 20, -1, -1, 1'b1);
    // Index 5 is the first FEEDBACK cycle: CLEAR, LOAD, CALC x3, FEEDBACK.
    run_job("abort_feedback", 2'b10, 2, 1'b1, 1'b1, 1'b0, 0, 5, -1, 1'b1);
    test_idle_start_abort();
    run_job("max_passes", 2'b01, (1 << PASS_W) - 1, 1'b0, 1'b1, 1'b1, 0, -1, -1, 1'b1);
    test_pe_sum();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
